// File: rtl/op_issuer_pkg.sv
// Shared types and widths for the op issuer and its timeout timer.
package op_issuer_pkg;

   localparam int OP_W     = 32;
   localparam int OP_SEL_W = 3;
   localparam int TIMER_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // True when a command index addresses one of the attached op units.
   function automatic logic sel_in_range(input logic [OP_SEL_W-1:0] sel,
                                         input int                  n_ops);
      return int'(sel) < n_ops;
   endfunction

endpackage

// File: rtl/op_issuer_timer.sv
// WAIT-state watchdog: counts WAIT cycles and flags the last allowed one.
module op_issuer_timer
   import op_issuer_pkg::*;
#(
   parameter int TIMEOUT = 63
) (
   input  logic c,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] count;

   // Counter: clear has priority over enable so ISSUE always restarts from zero.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TIMER_W'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/op_issuer.sv
// Single-outstanding issuer for the bank of pipelined op units: accepts a
// command, pulses the selected unit's start, waits (bounded) for its done,
// and hands the captured result back on the response port.
//
// Both cmd and rsp ports use the same handshake: a transfer happens on a
// rising clock edge where valid and ready are both high; the sender holds
// valid and its payload unchanged until that edge, and ready may depend on
// nothing but local state.
module op_issuer
   import op_issuer_pkg::*;
#(
   parameter int N_OPS   = 4,
   parameter int TIMEOUT = 63
) (
   input  logic                    c,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [OP_SEL_W-1:0]     cmd_op,
   input  logic [OP_W-1:0]         cmd_d,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [OP_W-1:0]         rsp_q,
   output logic                    rsp_err,
   output logic [OP_W-1:0]         op_d,
   output logic [N_OPS-1:0]        op_start,
   input  logic [N_OPS-1:0]        op_done,
   input  logic [OP_W*N_OPS-1:0]   op_q,
   output logic                    busy,
   output state_t                  fsm_state
);

   state_t                state_q;
   state_t                state_d;
   logic [OP_SEL_W-1:0]   sel_q;

   logic                  cmd_in_range;
   logic [N_OPS-1:0]      start_vec;
   logic                  done_sel;
   logic [OP_W-1:0]       q_sel;
   logic                  expired;

   logic                  accept;
   logic                  take_done;
   logic                  take_timeout;
   logic                  rsp_hs;

   assign cmd_in_range = sel_in_range(cmd_op, N_OPS);

   // One-hot start pattern for the unit addressed by the incoming command.
   always_comb begin
      start_vec = '0;
      for (int i = 0; i < N_OPS; i++) begin
         if (cmd_op == OP_SEL_W'(i)) begin
            start_vec[i] = 1'b1;
         end
      end
   end

   // Pick the done bit and result slice of the latched unit only; other
   // units' done lines never reach the FSM.
   always_comb begin
      done_sel = 1'b0;
      q_sel    = '0;
      for (int i = 0; i < N_OPS; i++) begin
         if (sel_q == OP_SEL_W'(i)) begin
            done_sel = op_done[i];
            q_sel    = op_q[i*OP_W +: OP_W];
         end
      end
   end

   // Bounds each WAIT: cleared while issuing, counting only in WAIT.
   op_issuer_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .c       (c),
      .rst_n   (rst_n),
      .clr     (state_q == ISSUE),
      .en      (state_q == WAIT),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus the one-cycle events the datapath acts on.
   // In WAIT a done beats a simultaneous timer expiry.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      take_done    = 1'b0;
      take_timeout = 1'b0;
      rsp_hs       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = cmd_in_range ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (done_sel) begin
               take_done = 1'b1;
               state_d   = RESP;
            end else if (expired) begin
               take_timeout = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_hs  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs: operand latch, start pulse and response payload.
   // A bad index goes straight to RESP with an error and never pulses start.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= '0;
         op_d      <= '0;
         op_start  <= '0;
         rsp_valid <= 1'b0;
         rsp_q     <= '0;
         rsp_err   <= 1'b0;
      end else begin
         op_start <= '0;
         if (accept) begin
            sel_q <= cmd_op;
            op_d  <= cmd_d;
            if (cmd_in_range) begin
               op_start <= start_vec;
            end else begin
               rsp_valid <= 1'b1;
               rsp_q     <= '0;
               rsp_err   <= 1'b1;
            end
         end
         if (take_done) begin
            rsp_valid <= 1'b1;
            rsp_q     <= q_sel;
            rsp_err   <= 1'b0;
         end
         if (take_timeout) begin
            rsp_valid <= 1'b1;
            rsp_q     <= '0;
            rsp_err   <= 1'b1;
         end
         if (rsp_hs) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign fsm_state = state_q;

endmodule

// File: tb/tb_op_issuer.sv
// Bench for op_issuer: directed scenarios plus randomized ops, checked
// every cycle against a transaction-level model of the issuer.
module tb_op_issuer;
  import op_issuer_pkg::*;

  localparam int N_OPS   = 4;
  localparam int TIMEOUT = 63;

  // ---------------- clock / reset / DUT ----------------
  logic                 c = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 rsp_ready = 1'b0;
  logic [2:0]           cmd_op = '0;
  logic [31:0]          cmd_d = '0;
  logic                 cmd_ready, rsp_valid, rsp_err, busy;
  logic [31:0]          rsp_q, op_d;
  logic [N_OPS-1:0]     op_start;
  logic [N_OPS-1:0]     op_done = '0;
  logic [32*N_OPS-1:0]  op_q = '0;
  state_t               fsm_state;

  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc++;

  op_issuer #(.N_OPS(N_OPS), .TIMEOUT(TIMEOUT)) dut (
    .c(c), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_d(cmd_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .op_d(op_d), .op_start(op_start), .op_done(op_done), .op_q(op_q),
    .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- transaction model ----------------
  bit          started  = 0;
  bit          m_active = 0;
  bit          m_bad    = 0;
  bit          m_err    = 0;
  int          m_acc    = 0;
  int          m_rise   = 0;
  logic [2:0]  m_op     = '0;
  logic [31:0] m_q      = '0;
  logic [31:0] m_d      = '0;

  int          obs_rise = 0;
  int          start_cnt = 0;
  logic [31:0] obs_q = '0;
  logic        obs_err = 1'b0;

  // Response timing/content from the op's description. rise = cycle index
  // (1 = cycle after the accept edge) at which rsp_valid must first be high.
  function automatic void predict(input int op, input int k, input logic [31:0] q,
                                  output int rise, output logic [31:0] eq, output bit err);
    if (op >= N_OPS) begin
      rise = 1; eq = '0; err = 1;
    end else if (k <= TIMEOUT) begin
      rise = k + 2; eq = q; err = 0;
    end else begin
      rise = TIMEOUT + 2; eq = '0; err = 1;
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge c) begin
    int               n;
    bit               ev;
    logic [N_OPS-1:0] es;
    if (started) begin
      n  = cyc - m_acc + 1;
      ev = m_active && (n >= m_rise);
      es = '0;
      if (m_active && !m_bad && n == 1) es[m_op] = 1'b1;
      chk("cmd_ready", cmd_ready, !m_active);
      chk("busy", busy, m_active);
      chk("op_start", op_start, es);
      chk("rsp_valid", rsp_valid, ev);
      chk("op_d", op_d, m_d);
      if (ev) begin
        chk("rsp_q", rsp_q, m_q);
        chk("rsp_err", rsp_err, m_err);
      end
      if (!rst_n) begin
        chk("rst_rsp_q", rsp_q, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
      end
      if (op_start != '0) start_cnt++;
      if (m_active && rsp_valid && obs_rise == 0) begin
        obs_rise = n; obs_q = rsp_q; obs_err = rsp_err;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Op-unit bank for cycle n of the current op: random results everywhere,
  // optional random done on other units, the selected unit's done only at
  // n == 1+k (or harmlessly in IDLE/ISSUE/RESP), plus one directed stray.
  task automatic drive_units(input int n, input int op, input int k, input logic [31:0] q,
                             input int rise, input bit rnd, input int stray_u, input int stray_n);
    logic [N_OPS-1:0]    dn;
    logic [32*N_OPS-1:0] qq;
    dn = '0;
    for (int i = 0; i < N_OPS; i++) begin
      qq[i*32 +: 32] = $urandom;
      if (rnd && $urandom_range(0, 9) == 0) dn[i] = 1'b1;
    end
    if (op < N_OPS) begin
      dn[op] = 1'b0;
      if (rnd && (n <= 1 || n >= rise) && $urandom_range(0, 3) == 0) dn[op] = 1'b1;
      if (n == 1 + k) begin
        dn[op] = 1'b1;
        qq[op*32 +: 32] = q;
      end
    end
    if (stray_u >= 0 && n == stray_n) dn[stray_u] = 1'b1;
    op_done = dn;
    op_q    = qq;
  endtask

  task automatic idle_cycles(input int cnt);
    cmd_valid = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      drive_units(0, 7, 0, 32'h0, 1, 1, -1, 0);
      rsp_ready = 1'($urandom_range(0, 1));
      @(posedge c); #1;
    end
  endtask

  // One complete op. Called at #1 after an edge with the issuer idle.
  // stall>0 holds rsp_ready low for that many cycles of valid response;
  // nxt leaves the following command pending on the port during the op.
  task automatic run_op(input int op, input logic [31:0] d, input int k, input logic [31:0] q,
                        input int stall, input bit rnd, input int stray_u, input int stray_n,
                        input bit nxt, input int nxt_op, input logic [31:0] nxt_d);
    int          rise;
    logic [31:0] eq;
    bit          err;
    int          n;
    bit          rdy;
    predict(op, k, q, rise, eq, err);
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_d = d; rsp_ready = 1'b0;
    drive_units(0, op, k, q, rise, rnd, stray_u, stray_n);
    @(posedge c); #1;
    m_active = 1; m_acc = cyc; m_d = d; m_op = 3'(op); m_bad = (op >= N_OPS);
    m_rise = rise; m_q = eq; m_err = err;
    obs_rise = 0; start_cnt = 0;
    cmd_valid = nxt; cmd_op = 3'(nxt_op); cmd_d = nxt_d;
    n = 1;
    forever begin
      drive_units(n, op, k, q, rise, rnd, stray_u, stray_n);
      if (stall > 0)           rdy = (n >= rise + stall);
      else if (n >= rise + 6)  rdy = 1;
      else if (rnd)            rdy = 1'($urandom_range(0, 1));
      else                     rdy = 1;
      rsp_ready = rdy;
      @(posedge c); #1;
      if (n >= rise && rdy) begin
        m_active = 0;
        break;
      end
      n++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_q"}, rsp_q, 32'h0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_op_start"}, op_start, '0);
    chk({tag, "_op_d"}, op_d, 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Op on unit 3 with done due at k=38, abandoned by reset in WAIT cycle 15.
  task automatic reset_mid_op();
    int          rise;
    logic [31:0] eq;
    bit          err;
    logic [31:0] d;
    logic [31:0] q;
    d = $urandom; q = $urandom;
    predict(3, 38, q, rise, eq, err);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_d = d; rsp_ready = 1'b1;
    drive_units(0, 3, 38, q, rise, 0, -1, 0);
    @(posedge c); #1;
    m_active = 1; m_acc = cyc; m_d = d; m_op = 3'd3; m_bad = 0;
    m_rise = rise; m_q = eq; m_err = err;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 46; n++) begin
      drive_units(n, 3, 38, q, rise, 0, -1, 0);
      if (n == 16) begin
        rst_n = 1'b0;
        #1;
        m_active = 0; m_d = '0;
        reset_chk("midrst");
      end
      if (n == 18) rst_n = 1'b1;
      @(posedge c); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d1, d2, q1, q2;
    int          op, k;

    #2;
    reset_chk("por");
    started = 1;
    repeat (2) @(posedge c);
    #1 rst_n = 1'b1;
    @(posedge c); #1;

    // Normal op: sin-like unit, done 38 cycles after start.
    run_op(0, 32'h3FC90FDB, 38, 32'h3F800000, 0, 0, -1, 0, 0, 0, 32'h0);
    chk("norm_rise", obs_rise, 40);
    chk("norm_q", obs_q, 32'h3F800000);
    chk("norm_err", obs_err, 1'b0);
    chk("norm_starts", start_cnt, 1);

    // Bad index: immediate error, no start.
    run_op(5, 32'h12345678, 10, 32'hDEADBEEF, 0, 0, -1, 0, 0, 0, 32'h0);
    chk("bad_rise", obs_rise, 1);
    chk("bad_q", obs_q, 32'h0);
    chk("bad_err", obs_err, 1'b1);
    chk("bad_starts", start_cnt, 0);

    // Timeout with a stray done from unit 1 at cycle 10.
    run_op(2, 32'hCAFEF00D, 300, 32'h0, 0, 0, 1, 10, 0, 0, 32'h0);
    chk("to_rise", obs_rise, 65);
    chk("to_q", obs_q, 32'h0);
    chk("to_err", obs_err, 1'b1);
    chk("to_starts", start_cnt, 1);

    // Backpressure: 20-cycle stall with the next command already pending.
    d1 = $urandom; d2 = $urandom; q1 = $urandom; q2 = $urandom;
    run_op(1, d1, 5, q1, 20, 0, -1, 0, 1, 3, d2);
    chk("bp_rise", obs_rise, 7);
    chk("bp_q", obs_q, q1);
    run_op(3, d2, 7, q2, 0, 0, -1, 0, 0, 0, 32'h0);
    chk("bp2_rise", obs_rise, 9);
    chk("bp2_q", obs_q, q2);

    // Done arrives on the timer-expiry cycle: done wins.
    q1 = $urandom;
    run_op(0, 32'h0BADCAFE, TIMEOUT, q1, 0, 0, -1, 0, 0, 0, 32'h0);
    chk("coll_rise", obs_rise, 65);
    chk("coll_q", obs_q, q1);
    chk("coll_err", obs_err, 1'b0);

    // Reset in the middle of an op, then a clean op afterwards.
    reset_mid_op();
    q1 = $urandom;
    run_op(2, 32'h55AA55AA, 4, q1, 0, 0, -1, 0, 0, 0, 32'h0);
    chk("post_rst_rise", obs_rise, 6);
    chk("post_rst_q", obs_q, q1);

    // Randomized ops with stray done traffic and random response readiness.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) op = $urandom_range(4, 7);
      else                           op = $urandom_range(0, N_OPS - 1);
      case ($urandom_range(0, 5))
        0:       k = TIMEOUT;
        1:       k = $urandom_range(TIMEOUT + 1, TIMEOUT + 8);
        2:       k = 1;
        default: k = $urandom_range(1, 40);
      endcase
      run_op(op, $urandom, k, $urandom, ($urandom_range(0, 5) == 0) ? 3 : 0,
             1, -1, 0, 0, 0, 32'h0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
